// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo constants for the Common Data Bus arbiter: bus widths,
// functional-unit ids and a small wrap-around index helper.
package cdb_arbiter_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NUM_FU = 5;

   typedef enum logic [2:0] {
      FU_ADD   = 3'd0,
      FU_LOGIC = 3'd1,
      FU_MUL   = 3'd2,
      FU_LOAD  = 3'd3,
      FU_STORE = 3'd4
   } fu_id_e;

   // Returns base+off reduced modulo n with an explicit compare, so non
   // power-of-two requester counts wrap correctly (base < n, off < n).
   function automatic int wrap_add(input int base, input int off, input int n);
      int sum;
      sum = base + off;
      if (sum >= n) begin
         sum = sum - n;
      end else begin
         sum = sum;
      end
      return sum;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the requester-side and broadcast-side CDB signals.
// master = functional units / environment, slave = the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 5,
   parameter int TAG_W   = 5,
   parameter int DATA_W  = 32
) ();

   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ*TAG_W-1:0]  tag_i;
   logic [NUM_REQ*DATA_W-1:0] val_i;
   logic                      flush_i;
   logic [NUM_REQ-1:0]        grant_o;
   logic                      out_broadcast;
   logic [TAG_W-1:0]          out_tag;
   logic [DATA_W-1:0]         out_val;

   modport master (
      output req_i, tag_i, val_i, flush_i,
      input  grant_o, out_broadcast, out_tag, out_val
   );

   modport slave (
      input  req_i, tag_i, val_i, flush_i,
      output grant_o, out_broadcast, out_tag, out_val
   );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of vec at or
// after ptr, wrapping modulo NUM_REQ. Returns it one-hot plus its index.
module cdb_arbiter_rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] vec,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [NUM_REQ-1:0] gnt_s;
   logic [IDX_W-1:0]   idx_s;
   logic               any_s;

   // Scan from ptr upward with wrap; the first hit wins.
   always_comb begin
      gnt_s = {NUM_REQ{1'b0}};
      idx_s = {IDX_W{1'b0}};
      any_s = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!any_s && vec[wrap_add(int'(ptr), off, NUM_REQ)]) begin
            any_s = 1'b1;
            idx_s = IDX_W'(wrap_add(int'(ptr), off, NUM_REQ));
            gnt_s[wrap_add(int'(ptr), off, NUM_REQ)] = 1'b1;
         end else begin
            any_s = any_s;
         end
      end
   end

   assign gnt = gnt_s;
   assign idx = idx_s;
   assign any = any_s;

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks at most one functional-unit result per cycle
// (two priority classes, round-robin inside each, starvation guard for the
// low class) and registers the winner's tag/value onto the bus.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int                     NUM_REQ      = NUM_FU,
   parameter int                     TAG_W        = cdb_arbiter_pkg::TAG_W,
   parameter int                     DATA_W       = cdb_arbiter_pkg::DATA_W,
   parameter logic [NUM_REQ-1:0]     PRIO_MASK    = 5'b01000,
   parameter int                     STARVE_LIMIT = 2
) (
   input logic          clk,
   input logic          rst_n,
   cdb_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]   rr_ptr_r;
   logic [CNT_W-1:0]   starve_cnt_r;
   logic               out_broadcast_r;
   logic [TAG_W-1:0]   out_tag_r;
   logic [DATA_W-1:0]  out_val_r;

   logic [NUM_REQ-1:0] hi_s;
   logic [NUM_REQ-1:0] lo_s;
   logic               use_hi_s;
   logic [NUM_REQ-1:0] cand_s;
   logic [NUM_REQ-1:0] pick_gnt_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               pick_any_s;
   logic               grant_valid_s;
   logic [NUM_REQ-1:0] grant_s;

   logic [TAG_W-1:0]   tag_arr_s [NUM_REQ];
   logic [DATA_W-1:0]  val_arr_s [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign tag_arr_s[i] = bus.tag_i[i*TAG_W +: TAG_W];
      assign val_arr_s[i] = bus.val_i[i*DATA_W +: DATA_W];
   end

   // Class select: high class wins unless the low class has been passed over
   // STARVE_LIMIT times in a row.
   always_comb begin
      hi_s = bus.req_i & PRIO_MASK;
      lo_s = bus.req_i & ~PRIO_MASK;
      if ((hi_s != {NUM_REQ{1'b0}}) &&
          ((lo_s == {NUM_REQ{1'b0}}) || (starve_cnt_r < STARVE_MAX))) begin
         use_hi_s = 1'b1;
         cand_s   = hi_s;
      end else begin
         use_hi_s = 1'b0;
         cand_s   = lo_s;
      end
   end

   cdb_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .vec (cand_s),
      .ptr (rr_ptr_r),
      .gnt (pick_gnt_s),
      .idx (pick_idx_s),
      .any (pick_any_s)
   );

   assign grant_valid_s = pick_any_s & ~bus.flush_i;

   // Grant is combinational for the requesters but held low during reset.
   always_comb begin
      if (rst_n && grant_valid_s) begin
         grant_s = pick_gnt_s;
      end else begin
         grant_s = {NUM_REQ{1'b0}};
      end
   end

   assign bus.grant_o = grant_s;

   // Pointer, starvation counter and bus register update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r        <= {IDX_W{1'b0}};
         starve_cnt_r    <= {CNT_W{1'b0}};
         out_broadcast_r <= 1'b0;
         out_tag_r       <= {TAG_W{1'b0}};
         out_val_r       <= {DATA_W{1'b0}};
      end else if (grant_valid_s) begin
         rr_ptr_r        <= (pick_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : pick_idx_s + 1'b1;
         out_broadcast_r <= 1'b1;
         out_tag_r       <= tag_arr_s[pick_idx_s];
         out_val_r       <= val_arr_s[pick_idx_s];
         if (use_hi_s && (lo_s != {NUM_REQ{1'b0}})) begin
            starve_cnt_r <= (starve_cnt_r == STARVE_MAX) ? STARVE_MAX : starve_cnt_r + 1'b1;
         end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
         end
      end else begin
         // No grant (flush or nothing pending): tag/value hold for observability.
         out_broadcast_r <= 1'b0;
         starve_cnt_r    <= {CNT_W{1'b0}};
      end
   end

   assign bus.out_broadcast = out_broadcast_r;
   assign bus.out_tag       = out_tag_r;
   assign bus.out_val       = out_val_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors followed by
// hand-written reset sequences.
module tb_cdb_arbiter;

   localparam int N  = 5;
   localparam int TW = 5;
   localparam int DW = 32;

   logic clk;
   logic rst_n;

   int total;
   int bad;

   cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(
      .NUM_REQ      (N),
      .TAG_W        (TW),
      .DATA_W       (DW),
      .PRIO_MASK    (5'b01000),
      .STARVE_LIMIT (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]    req;
      logic [N*TW-1:0] tags;
      logic [N*DW-1:0] vals;
      logic            flush;
      logic [N-1:0]    g;
      logic            b;
      logic [TW-1:0]   t;
      logic [DW-1:0]   v;
      logic [2:0]      rr;
   } vec_t;

   vec_t vecs [14];

   function automatic logic [N*TW-1:0] ts(input int k, input int t);
      logic [N*TW-1:0] r;
      r = '0;
      r[k*TW +: TW] = TW'(t);
      return r;
   endfunction

   function automatic logic [N*DW-1:0] vs(input int k, input int v);
      logic [N*DW-1:0] r;
      r = '0;
      r[k*DW +: DW] = DW'(v);
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.req_i   = 5'b11111;
      bus.tag_i   = '0;
      bus.val_i   = '0;
      bus.flush_i = 1'b0;

      // Reset with every requester asking.
      repeat (2) @(negedge clk);
      check("rst_grant", 64'(bus.grant_o), 64'd0);
      check("rst_bcast", 64'(bus.out_broadcast), 64'd0);
      check("rst_tag",   64'(bus.out_tag), 64'd0);
      check("rst_val",   64'(bus.out_val), 64'd0);

      // add=0 logic=1 mul=2 load=3 store=4; only load is high class.
      vecs[0]  = '{5'b00101, ts(0,5)|ts(2,9), vs(0,1)|vs(2,15), 1'b0, 5'b00001, 1'b1, 5'd5, 32'd1,   3'd1};
      vecs[1]  = '{5'b00100, ts(2,9),         vs(2,15),         1'b0, 5'b00100, 1'b1, 5'd9, 32'd15,  3'd3};
      vecs[2]  = '{5'b00010, ts(1,3),         vs(1,7),          1'b0, 5'b00010, 1'b1, 5'd3, 32'd7,   3'd2};
      vecs[3]  = '{5'b00000, '0,              '0,               1'b0, 5'b00000, 1'b0, 5'd3, 32'd7,   3'd2};
      vecs[4]  = '{5'b01001, ts(3,1)|ts(0,5), vs(3,101)|vs(0,55), 1'b0, 5'b01000, 1'b1, 5'd1, 32'd101, 3'd4};
      vecs[5]  = '{5'b01001, ts(3,2)|ts(0,5), vs(3,102)|vs(0,55), 1'b0, 5'b01000, 1'b1, 5'd2, 32'd102, 3'd4};
      vecs[6]  = '{5'b01001, ts(3,3)|ts(0,5), vs(3,103)|vs(0,55), 1'b0, 5'b00001, 1'b1, 5'd5, 32'd55,  3'd1};
      vecs[7]  = '{5'b01000, ts(3,3),         vs(3,103),        1'b0, 5'b01000, 1'b1, 5'd3, 32'd103, 3'd4};
      vecs[8]  = '{5'b01000, ts(3,4),         vs(3,104),        1'b0, 5'b01000, 1'b1, 5'd4, 32'd104, 3'd4};
      vecs[9]  = '{5'b10001, ts(4,7)|ts(0,6), vs(4,70)|vs(0,60), 1'b0, 5'b10000, 1'b1, 5'd7, 32'd70,  3'd0};
      vecs[10] = '{5'b00001, ts(0,6),         vs(0,60),         1'b0, 5'b00001, 1'b1, 5'd6, 32'd60,  3'd1};
      vecs[11] = '{5'b00100, ts(2,8),         vs(2,80),         1'b1, 5'b00000, 1'b0, 5'd6, 32'd60,  3'd1};
      vecs[12] = '{5'b00100, ts(2,8),         vs(2,80),         1'b0, 5'b00100, 1'b1, 5'd8, 32'd80,  3'd3};
      vecs[13] = '{5'b00000, '0,              '0,               1'b0, 5'b00000, 1'b0, 5'd8, 32'd80,  3'd3};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rst_n       = 1'b1;
         bus.req_i   = vecs[i].req;
         bus.tag_i   = vecs[i].tags;
         bus.val_i   = vecs[i].vals;
         bus.flush_i = vecs[i].flush;
         #1;
         check($sformatf("v%0d_grant", i), 64'(bus.grant_o), 64'(vecs[i].g));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_bcast", i), 64'(bus.out_broadcast), 64'(vecs[i].b));
         check($sformatf("v%0d_tag", i),   64'(bus.out_tag), 64'(vecs[i].t));
         check($sformatf("v%0d_val", i),   64'(bus.out_val), 64'(vecs[i].v));
         check($sformatf("v%0d_rr", i),    64'(dut.rr_ptr_r), 64'(vecs[i].rr));
      end

      // Async reset in the middle of a live broadcast.
      @(negedge clk);
      bus.req_i = 5'b00010;
      bus.tag_i = ts(1,3);
      bus.val_i = vs(1,7);
      @(posedge clk);
      #1;
      check("mid_bcast_pre", 64'(bus.out_broadcast), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_bcast", 64'(bus.out_broadcast), 64'd0);
      check("mid_tag",   64'(bus.out_tag), 64'd0);
      check("mid_val",   64'(bus.out_val), 64'd0);
      check("mid_grant", 64'(bus.grant_o), 64'd0);
      check("mid_rr",    64'(dut.rr_ptr_r), 64'd0);

      // After release, arbitration restarts from pointer 0: logic beats store.
      @(negedge clk);
      rst_n     = 1'b1;
      bus.req_i = 5'b10010;
      bus.tag_i = ts(1,11) | ts(4,12);
      bus.val_i = vs(1,111) | vs(4,112);
      #1;
      check("rel_grant", 64'(bus.grant_o), 64'b00010);
      @(posedge clk);
      #1;
      check("rel_tag", 64'(bus.out_tag), 64'd11);
      check("rel_val", 64'(bus.out_val), 64'd111);
      check("rel_rr",  64'(dut.rr_ptr_r), 64'd2);

      @(negedge clk);
      bus.req_i = 5'b10000;
      bus.tag_i = ts(4,12);
      bus.val_i = vs(4,112);
      #1;
      check("rel2_grant", 64'(bus.grant_o), 64'b10000);
      @(posedge clk);
      #1;
      check("rel2_tag", 64'(bus.out_tag), 64'd12);
      check("rel2_rr",  64'(dut.rr_ptr_r), 64'd0);

      @(negedge clk);
      bus.req_i = 5'b00000;
      @(posedge clk);
      #1;
      check("end_bcast", 64'(bus.out_broadcast), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
